inst_prefetch: RTL

Instruction prefetch stage that sits between the system bus and the core's instruction register path. It fetches sequential words ahead of execution into a small FIFO and hands {pc, instruction, error} entries to the core over a valid/ready handshake. On a control-flow redirect it flushes the FIFO, restarts fetching at the new PC, and discards responses still in flight.

---
 rtl/inst_prefetch.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/inst_prefetch.sv
// Instruction prefetch stage. Fetches sequential words ahead of the core into a
// small FIFO of {pc, inst, err} entries. A redirect flushes the FIFO, restarts
// fetching at the new PC and drops any responses still in flight.
module inst_prefetch #(
    parameter int               Width          = 32,
    parameter int               Depth          = 4,
    parameter int               MaxOutstanding = 2,
    parameter logic [Width-1:0] ResetValue     = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             bus_req,
    output logic [Width-1:0] bus_addr,
    input  logic             bus_gnt,
    input  logic             bus_rvalid,
    input  logic [Width-1:0] bus_rdata,
    input  logic             bus_err,
    input  logic             redirect,
    input  logic [Width-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_inst,
    output logic [Width-1:0] out_pc,
    output logic             out_err
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam int OutW = $clog2(MaxOutstanding + 1);
    // Wide enough to hold kept-in-flight plus occupancy (at most 2*Depth).
    localparam int SumW = CntW + 1;

    logic [Width-1:0] fetch_pc_q, fetch_pc_d;
    logic [Width-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [OutW-1:0]  outst_q, outst_d;
    logic [OutW-1:0]  discard_q, discard_d;
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;

    logic [Width-1:0] pc_mem_q   [Depth];
    logic [Width-1:0] inst_mem_q [Depth];
    logic             err_mem_q  [Depth];

    logic             gnt_fire;
    logic             rsp_keep;
    logic             push_en;
    logic             pop_en;
    logic [SumW-1:0]  reserved;

    // Slots already claimed: responses we will keep plus entries sitting in the FIFO.
    assign reserved = SumW'(outst_q - discard_q) + SumW'(count_q);

    assign bus_req  = !rst && !redirect
                      && (reserved < SumW'(Depth))
                      && (outst_q < OutW'(MaxOutstanding));
    assign bus_addr = fetch_pc_q;

    assign gnt_fire = bus_req && bus_gnt;
    assign rsp_keep = bus_rvalid && (discard_q == '0);
    assign push_en  = rsp_keep && !redirect;
    assign pop_en   = out_valid && out_ready;

    assign out_valid = (count_q != '0);
    assign out_inst  = inst_mem_q[head_q];
    assign out_pc    = pc_mem_q[head_q];
    assign out_err   = err_mem_q[head_q];

    // Next-state for pointers, counters and fetch addresses; redirect overrides push/pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + Width'(4);
        end

        case ({gnt_fire, bus_rvalid})
            2'b10:   outst_d = outst_q + OutW'(1);
            2'b01:   outst_d = outst_q - OutW'(1);
            default: outst_d = outst_q;
        endcase

        if (redirect) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = {redirect_pc[Width-1:2], 2'b00};
            resp_pc_d  = {redirect_pc[Width-1:2], 2'b00};
            // Every read still outstanding after this cycle belongs to the old stream.
            discard_d  = bus_rvalid ? (outst_q - OutW'(1)) : outst_q;
        end else begin
            if (bus_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - OutW'(1);
            end
            if (rsp_keep) begin
                tail_d    = tail_q + PtrW'(1);
                resp_pc_d = resp_pc_q + Width'(4);
            end
            if (pop_en) begin
                head_d = head_q + PtrW'(1);
            end
            case ({rsp_keep, pop_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= ResetValue;
            resp_pc_q  <= ResetValue;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // FIFO storage; cleared on reset so the head outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
                err_mem_q[i]  <= 1'b0;
            end
        end else if (push_en) begin
            pc_mem_q[tail_q]   <= resp_pc_q;
            inst_mem_q[tail_q] <= bus_rdata;
            err_mem_q[tail_q]  <= bus_err;
        end
    end

endmodule
